// File: rtl/weighted_rr_arbiter.sv
// weighted_rr_arbiter: registered weighted round-robin arbiter with fixed-priority fallback.
// The winner holds its grant for up to w_eff consecutive requesting cycles, then priority rotates
// to the channel after the holder.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   en         : gates new grants; a running burst always completes
//   mode       : 0 = weighted round-robin, 1 = fixed priority (index 0 highest)
//   req        : level-sensitive request vector
//   weight     : per-channel burst weight, channel i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]
//   gnt        : registered one-hot grant (or zero)
//   gnt_valid  : registered, equals |gnt
//   gnt_id     : index of granted channel, holds last value while idle
module weighted_rr_arbiter #(
    parameter int unsigned REQ_WIDTH    = 8,
    parameter int unsigned WEIGHT_WIDTH = 4,
    parameter int unsigned ID_WIDTH     = $clog2(REQ_WIDTH)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic                              mode,
    input  logic [REQ_WIDTH-1:0]              req,
    input  logic [REQ_WIDTH*WEIGHT_WIDTH-1:0] weight,
    output logic [REQ_WIDTH-1:0]              gnt,
    output logic                              gnt_valid,
    output logic [ID_WIDTH-1:0]               gnt_id
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t                  state;
    logic [ID_WIDTH-1:0]     ptr;
    logic [WEIGHT_WIDTH-1:0] cnt;

    // Unpack the flat weight bus into per-channel entries
    logic [WEIGHT_WIDTH-1:0] w_arr [REQ_WIDTH];

    for (genvar g = 0; g < REQ_WIDTH; g++) begin : g_w
        assign w_arr[g] = weight[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end

    logic                    release_c;
    logic [ID_WIDTH-1:0]     nxt_ptr_c;
    logic [ID_WIDTH-1:0]     sptr_c;
    logic [ID_WIDTH-1:0]     cand_c;
    logic                    win_found_c;
    logic [ID_WIDTH-1:0]     win_id_c;
    logic [WEIGHT_WIDTH-1:0] win_w_c;

    // Burst ends when the holder drops its request or consumes its last beat
    assign release_c = !req[gnt_id] || (cnt <= WEIGHT_WIDTH'(1));

    // Pointer just past the holder, wrapping for any REQ_WIDTH
    assign nxt_ptr_c = (32'(gnt_id) == REQ_WIDTH - 1) ? '0 : gnt_id + 1'b1;

    // On release the rotated pointer is used in the same cycle's search
    assign sptr_c = (state == GRANT && release_c) ? nxt_ptr_c : ptr;

    // Winner search: rotating scan from sptr_c, or plain LSB-first in fixed mode
    always_comb begin
        win_found_c = 1'b0;
        win_id_c    = '0;
        cand_c      = '0;
        for (int unsigned i = 0; i < REQ_WIDTH; i++) begin
            cand_c = ID_WIDTH'(mode ? i : (32'(sptr_c) + i) % REQ_WIDTH);
            if (!win_found_c && req[cand_c]) begin
                win_found_c = 1'b1;
                win_id_c    = cand_c;
            end
        end
    end

    // Zero weight is treated as a single-beat burst
    assign win_w_c = (w_arr[win_id_c] == '0) ? WEIGHT_WIDTH'(1) : w_arr[win_id_c];

    // State, pointer, beat counter and registered grant outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (en && win_found_c) begin
                        gnt       <= REQ_WIDTH'(1) << win_id_c;
                        gnt_valid <= 1'b1;
                        gnt_id    <= win_id_c;
                        cnt       <= win_w_c;
                        state     <= GRANT;
                    end else begin
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!release_c) begin
                        cnt <= cnt - WEIGHT_WIDTH'(1);
                    end else begin
                        ptr <= nxt_ptr_c;
                        if (en && win_found_c) begin
                            gnt       <= REQ_WIDTH'(1) << win_id_c;
                            gnt_valid <= 1'b1;
                            gnt_id    <= win_id_c;
                            cnt       <= win_w_c;
                        end else begin
                            gnt       <= '0;
                            gnt_valid <= 1'b0;
                            cnt       <= '0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    gnt       <= '0;
                    gnt_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Bench for weighted_rr_arbiter: table of {en, mode, req, weight, expected gnt} vectors applied one
// per cycle; expected results are queued when a vector is driven and popped when the output is sampled.
module tb_weighted_rr_arbiter;

    localparam int unsigned N  = 8;
    localparam int unsigned WW = 4;
    localparam int unsigned IW = 3;

    logic            clk;
    logic            rst;
    logic            en;
    logic            mode;
    logic [N-1:0]    req;
    logic [N*WW-1:0] weight;
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic [IW-1:0]   gnt_id;

    weighted_rr_arbiter #(.REQ_WIDTH(N), .WEIGHT_WIDTH(WW)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .req       (req),
        .weight    (weight),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            rst_before;
        logic            en;
        logic            mode;
        logic [N-1:0]    req;
        logic [N*WW-1:0] weight;
        logic [N-1:0]    exp_gnt;
    } vec_t;

    typedef struct {
        logic [N-1:0]  gnt;
        logic [IW-1:0] id;
    } exp_t;

    vec_t          vecs[$];
    exp_t          sb[$];
    int            tests  = 0;
    int            fails  = 0;
    logic [IW-1:0] last_id = '0;
    logic          checking = 1'b0;

    function automatic void add(input logic r, input logic e, input logic m,
                                input logic [N-1:0] rq, input logic [N*WW-1:0] w,
                                input logic [N-1:0] x);
        vec_t v;
        v.rst_before = r; v.en = e; v.mode = m; v.req = rq; v.weight = w; v.exp_gnt = x;
        vecs.push_back(v);
    endfunction

    function automatic logic [IW-1:0] idx_of(input logic [N-1:0] g);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) if (g[i]) r = IW'(i);
        return r;
    endfunction

    task automatic check_out(input string name, input exp_t e);
        tests++;
        if (gnt !== e.gnt) begin
            fails++;
            $display("FAIL %s gnt: got %h want %h", name, gnt, e.gnt);
        end
        tests++;
        if (gnt_valid !== (e.gnt != '0)) begin
            fails++;
            $display("FAIL %s gnt_valid: got %b want %b", name, gnt_valid, (e.gnt != '0));
        end
        tests++;
        if (gnt_id !== e.id) begin
            fails++;
            $display("FAIL %s gnt_id: got %0d want %0d", name, gnt_id, e.id);
        end
    endtask

    // Drive one vector, queue its expectation, compare just after the sampling edge
    task automatic apply(input string name, input vec_t v);
        exp_t e;
        @(negedge clk);
        en = v.en; mode = v.mode; req = v.req; weight = v.weight;
        if (v.exp_gnt != '0) last_id = idx_of(v.exp_gnt);
        e.gnt = v.exp_gnt;
        e.id  = last_id;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            check_out(name, sb.pop_front());
        end
    endtask

    task automatic do_reset(input string name);
        exp_t e;
        @(negedge clk);
        rst = 1'b1; en = 1'b0; req = '0;
        @(posedge clk);
        #1;
        last_id = '0;
        e.gnt = '0; e.id = '0;
        check_out(name, e);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Grant must never have more than one bit set
    always @(negedge clk) begin
        if (checking) begin
            tests++;
            if ($countones(gnt) > 1) begin
                fails++;
                $display("FAIL onehot: got %h want at most one bit", gnt);
            end
        end
    end

    initial begin
        exp_t e;
        vec_t v;
        rst = 1'b1; en = 1'b0; mode = 1'b0; req = '0; weight = '0;

        // Plain round-robin, weights 1
        add(1, 1, 0, 8'hFF, 32'h11111111, 8'h01);
        add(0, 1, 0, 8'hFF, 32'h11111111, 8'h02);
        add(0, 1, 0, 8'hFF, 32'h11111111, 8'h04);
        add(0, 1, 0, 8'hFF, 32'h11111111, 8'h08);
        add(0, 1, 0, 8'hFF, 32'h11111111, 8'h10);
        add(0, 1, 0, 8'hFF, 32'h11111111, 8'h20);
        add(0, 1, 0, 8'hFF, 32'h11111111, 8'h40);
        add(0, 1, 0, 8'hFF, 32'h11111111, 8'h80);
        add(0, 1, 0, 8'hFF, 32'h11111111, 8'h01);
        // Weighted: channel 0 weight 3, channel 1 weight 1
        add(1, 1, 0, 8'h03, 32'h11111113, 8'h01);
        add(0, 1, 0, 8'h03, 32'h11111113, 8'h01);
        add(0, 1, 0, 8'h03, 32'h11111113, 8'h01);
        add(0, 1, 0, 8'h03, 32'h11111113, 8'h02);
        add(0, 1, 0, 8'h03, 32'h11111113, 8'h01);
        add(0, 1, 0, 8'h03, 32'h11111113, 8'h01);
        add(0, 1, 0, 8'h03, 32'h11111113, 8'h01);
        add(0, 1, 0, 8'h03, 32'h11111113, 8'h02);
        // Early drop of channel 2 (weight 4), then channel 5 with weight 0
        add(1, 1, 0, 8'h24, 32'h11111411, 8'h04);
        add(0, 1, 0, 8'h24, 32'h11111411, 8'h04);
        add(0, 1, 0, 8'h20, 32'h11111411, 8'h20);
        add(0, 1, 0, 8'h20, 32'h11011411, 8'h20);
        add(0, 1, 0, 8'h20, 32'h11011411, 8'h20);
        add(0, 1, 0, 8'h20, 32'h11011411, 8'h20);
        add(0, 1, 0, 8'h21, 32'h11011411, 8'h01);
        // Fixed priority, then back to round-robin from past the holder
        add(1, 1, 1, 8'hF0, 32'h11111111, 8'h10);
        add(0, 1, 1, 8'hF0, 32'h11111111, 8'h10);
        add(0, 1, 1, 8'hF0, 32'h11111111, 8'h10);
        add(0, 1, 0, 8'hF0, 32'h11111111, 8'h20);
        add(0, 1, 0, 8'hF0, 32'h11111111, 8'h40);
        add(0, 1, 0, 8'hF0, 32'h11111111, 8'h80);
        add(0, 1, 0, 8'hF0, 32'h11111111, 8'h10);
        // Enable low blocks grants; dropping it mid-burst lets the burst finish
        add(1, 0, 0, 8'hFF, 32'h11111111, 8'h00);
        add(0, 0, 0, 8'hFF, 32'h11111111, 8'h00);
        add(0, 0, 0, 8'hFF, 32'h11111111, 8'h00);
        add(0, 1, 0, 8'hFF, 32'h11111114, 8'h01);
        add(0, 0, 0, 8'hFF, 32'h11111114, 8'h01);
        add(0, 0, 0, 8'hFF, 32'h11111114, 8'h01);
        add(0, 0, 0, 8'hFF, 32'h11111114, 8'h01);
        add(0, 0, 0, 8'hFF, 32'h11111114, 8'h00);
        add(0, 0, 0, 8'hFF, 32'h11111114, 8'h00);
        // Maximum weight burst of 15 beats, then rotation to channel 1
        add(1, 1, 0, 8'h03, 32'h1111111F, 8'h01);
        for (int i = 0; i < 14; i++) add(0, 1, 0, 8'h03, 32'h1111111F, 8'h01);
        add(0, 1, 0, 8'h03, 32'h1111111F, 8'h02);

        repeat (2) @(posedge clk);
        checking = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.rst_before) do_reset($sformatf("reset_v%0d", i));
            apply($sformatf("vec%0d", i), v);
        end

        // Asynchronous reset in the third cycle of a weight-5 burst
        do_reset("reset_pre_async");
        v.rst_before = 0; v.en = 1; v.mode = 0; v.req = 8'hFF; v.weight = 32'h55555555;
        v.exp_gnt = 8'h01;
        apply("async_b1", v);
        apply("async_b2", v);
        apply("async_b3", v);
        #2;
        rst = 1'b1;
        #1;
        last_id = '0;
        e.gnt = '0; e.id = '0;
        check_out("async_rst", e);
        @(negedge clk);
        rst = 1'b0;
        apply("after_rst_first", v);
        apply("after_rst_second", v);

        checking = 1'b0;
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
